// File: rtl/tree_pkg.sv
// tree_pkg: shared FSM state and error codes for the runtime tree path engine.
package tree_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, ALLOC, DRAIN, RESP} tree_eng_state_e;
  localparam logic [1:0] ERR_OK           = 2'd0;
  localparam logic [1:0] ERR_BAD_ID       = 2'd1;
  localparam logic [1:0] ERR_CHILD_FULL   = 2'd2;
  localparam logic [1:0] ERR_MISS_OR_FULL = 2'd3;
endpackage

// File: rtl/tree_node_table.sv
// tree_node_table: node register array with a cursor read port, a child-id read port
// and one write port that stores a new node and appends it to its parent in the same cycle.
module tree_node_table #(
  parameter int IDENTIFIER_SIZE = 8,
  parameter int NODE_ADDR_SIZE  = 8,
  parameter int NUM_NODES       = 64,
  parameter int MAX_CHILDREN    = 4,
  parameter int KW              = $clog2(MAX_CHILDREN + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [NODE_ADDR_SIZE-1:0]  i_waddr,
  input  logic [IDENTIFIER_SIZE-1:0] i_wid,
  input  logic [NODE_ADDR_SIZE-1:0]  i_wparent,
  input  logic [NODE_ADDR_SIZE-1:0]  i_cursor,
  input  logic [KW-1:0]              i_k,
  output logic [NODE_ADDR_SIZE-1:0]  o_parent,
  output logic [KW-1:0]              o_cnt,
  output logic [NODE_ADDR_SIZE-1:0]  o_child,
  output logic [IDENTIFIER_SIZE-1:0] o_child_id
);
  localparam int AW = $clog2(NUM_NODES);
  localparam int CW = $clog2(MAX_CHILDREN);
  logic [IDENTIFIER_SIZE-1:0] r_id  [NUM_NODES];
  logic [NODE_ADDR_SIZE-1:0]  r_par [NUM_NODES];
  logic [KW-1:0]              r_cnt [NUM_NODES];
  logic [NODE_ADDR_SIZE-1:0]  r_ch  [NUM_NODES][MAX_CHILDREN];
  logic [AW-1:0] w_ca, w_wa, w_pa;
  logic w_unused;
  assign w_ca       = i_cursor[AW-1:0];
  assign w_wa       = i_waddr[AW-1:0];
  assign w_pa       = i_wparent[AW-1:0];
  assign o_parent   = r_par[w_ca];
  assign o_cnt      = r_cnt[w_ca];
  assign o_child    = r_ch[w_ca][i_k[CW-1:0]];
  assign o_child_id = r_id[o_child[AW-1:0]];
  // Address bits above the table depth and the k overflow bit never select storage.
  assign w_unused   = ^{i_cursor[NODE_ADDR_SIZE-1:AW], i_k[KW-1:CW]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_id[i]  <= '0;
        r_par[i] <= '0;
        r_cnt[i] <= '0;
        for (int j = 0; j < MAX_CHILDREN; j++) r_ch[i][j] <= '0;
      end
    end else if (i_clr) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        r_id[i]  <= '0;
        r_par[i] <= '0;
        r_cnt[i] <= '0;
        for (int j = 0; j < MAX_CHILDREN; j++) r_ch[i][j] <= '0;
      end
    end else if (i_we) begin
      r_id[w_wa]                        <= i_wid;
      r_par[w_wa]                       <= i_wparent;
      r_cnt[w_wa]                       <= '0;
      r_ch[w_pa][r_cnt[w_pa][CW-1:0]]   <= i_waddr;
      r_cnt[w_pa]                       <= r_cnt[w_pa] + 1'b1;
    end
  end
endmodule

// File: rtl/tree_path_engine.sv
// tree_path_engine: walks a streamed root-to-leaf id path through the node table,
// scanning one child per clock, optionally creating missing nodes, and returns the leaf.
module tree_path_engine
  import tree_pkg::*;
#(
  parameter int IDENTIFIER_SIZE = 8,
  parameter int NODE_ADDR_SIZE  = 8,
  parameter int NUM_NODES       = 64,
  parameter int MAX_CHILDREN    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [IDENTIFIER_SIZE-1:0] s_id,
  input  logic                       s_last,
  input  logic                       s_insert,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NODE_ADDR_SIZE-1:0]  m_addr,
  output logic                       m_found,
  output logic                       m_created,
  output logic [1:0]                 m_err,
  output logic [NODE_ADDR_SIZE-1:0]  used_cnt
);
  localparam int KW = $clog2(MAX_CHILDREN + 1);
  tree_eng_state_e            r_state;
  logic [IDENTIFIER_SIZE-1:0] r_id;
  logic                       r_last, r_ins, r_created;
  logic [KW-1:0]              r_k;
  logic [NODE_ADDR_SIZE-1:0]  r_cursor, r_free;
  logic [1:0]                 r_err;
  logic [NODE_ADDR_SIZE-1:0]  w_parent, w_child;
  logic [KW-1:0]              w_cnt;
  logic [IDENTIFIER_SIZE-1:0] w_child_id;
  logic                       w_take, w_clr, w_miss, w_hit, w_unused_parent;
  logic [1:0]                 w_miss_err;
  tree_node_table #(
    .IDENTIFIER_SIZE(IDENTIFIER_SIZE), .NODE_ADDR_SIZE(NODE_ADDR_SIZE),
    .NUM_NODES(NUM_NODES), .MAX_CHILDREN(MAX_CHILDREN), .KW(KW)
  ) u_table (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_we(r_state == ALLOC),
    .i_waddr(r_free), .i_wid(r_id), .i_wparent(r_cursor), .i_cursor(r_cursor), .i_k(r_k),
    .o_parent(w_parent), .o_cnt(w_cnt), .o_child(w_child), .o_child_id(w_child_id)
  );
  assign w_unused_parent = ^w_parent;
  // clr takes priority over a simultaneous element in IDLE.
  assign s_ready    = (r_state == IDLE && !clr) || r_state == DRAIN;
  assign w_take     = s_valid && s_ready;
  assign w_clr      = clr && r_state == IDLE;
  assign w_miss     = r_k == w_cnt;
  assign w_hit      = !w_miss && w_child_id == r_id;
  assign w_miss_err = !r_ins ? ERR_MISS_OR_FULL :
                      w_cnt == KW'(MAX_CHILDREN) ? ERR_CHILD_FULL :
                      r_free == NODE_ADDR_SIZE'(NUM_NODES) ? ERR_MISS_OR_FULL : ERR_OK;
  assign m_valid    = r_state == RESP;
  assign m_addr     = (m_valid && r_err == ERR_OK) ? r_cursor : '0;
  assign m_found    = m_valid && !r_created && r_err == ERR_OK;
  assign m_created  = m_valid && r_created;
  assign m_err      = m_valid ? r_err : ERR_OK;
  assign used_cnt   = r_free;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_last    <= 1'b0;
      r_ins     <= 1'b0;
      r_k       <= '0;
      r_cursor  <= '0;
      r_free    <= NODE_ADDR_SIZE'(1);
      r_created <= 1'b0;
      r_err     <= ERR_OK;
    end else begin
      case (r_state)
        IDLE: if (w_clr) r_free <= NODE_ADDR_SIZE'(1);
          else if (w_take) begin
            r_id   <= s_id;
            r_last <= s_last;
            r_k    <= '0;
            // Only the root cursor marks the first element of a path.
            if (r_cursor == '0) r_ins <= s_insert;
            if (s_id == '0) begin
              r_err   <= ERR_BAD_ID;
              r_state <= s_last ? RESP : DRAIN;
            end else r_state <= SCAN;
          end
        SCAN: if (w_hit) begin
            r_cursor <= w_child;
            r_state  <= r_last ? RESP : IDLE;
          end else if (w_miss) begin
            r_err   <= w_miss_err;
            r_state <= w_miss_err != ERR_OK ? (r_last ? RESP : DRAIN) : ALLOC;
          end else r_k <= r_k + 1'b1;
        ALLOC: begin
          r_cursor  <= r_free;
          r_free    <= r_free + 1'b1;
          r_created <= 1'b1;
          r_state   <= r_last ? RESP : IDLE;
        end
        DRAIN: if (w_take && s_last) r_state <= RESP;
        RESP: if (m_ready) begin
            r_cursor  <= '0;
            r_created <= 1'b0;
            r_err     <= ERR_OK;
            r_state   <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tree_path_engine.sv
// tb_tree_path_engine: directed paths checked every response cycle against a
// parent-pointer model of the tree, plus hand-computed literal expectations.
module tb_tree_path_engine;
  import tree_pkg::*;
  localparam int NN = 64;
  localparam int MC = 4;
  logic clk = 0, rst_n = 0, clr = 0, s_valid = 0, s_last = 0, s_insert = 0, m_ready = 0;
  logic [7:0] s_id = '0;
  logic s_ready, m_valid, m_found, m_created;
  logic [7:0] m_addr, used_cnt;
  logic [1:0] m_err;
  int total = 0, passed = 0;
  int mid[NN], mpar[NN], mused;
  int path[64], plen;
  int e_addr, e_found, e_created, e_err;
  int c_addr, c_found, c_created, c_err, lat;

  tree_path_engine #(.IDENTIFIER_SIZE(8), .NODE_ADDR_SIZE(8), .NUM_NODES(NN), .MAX_CHILDREN(MC)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id),
    .s_last(s_last), .s_insert(s_insert), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_found(m_found), .m_created(m_created), .m_err(m_err), .used_cnt(used_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int find_child(input int p, input int id);
    for (int n = 1; n < mused; n++) if (mpar[n] == p && mid[n] == id) return n;
    return 0;
  endfunction

  function automatic int nchild(input int p);
    int c = 0;
    for (int n = 1; n < mused; n++) if (mpar[n] == p) c++;
    return c;
  endfunction

  task automatic model_clear();
    mused = 1;
  endtask

  task automatic model_run(input bit ins);
    int cur = 0, err = 0, created = 0, c;
    for (int i = 0; i < plen; i++) begin
      if (err != 0) continue;
      if (path[i] == 0) begin err = 1; continue; end
      c = find_child(cur, path[i]);
      if (c != 0) cur = c;
      else if (!ins) err = 3;
      else if (nchild(cur) == MC) err = 2;
      else if (mused == NN) err = 3;
      else begin
        mid[mused] = path[i]; mpar[mused] = cur; cur = mused; mused++; created = 1;
      end
    end
    e_addr = err != 0 ? 0 : cur;
    e_found = (created == 0 && err == 0) ? 1 : 0;
    e_created = created;
    e_err = err;
  endtask

  task automatic set_path(input int n, input int a = 0, input int b = 0, input int c = 0);
    plen = n; path[0] = a; path[1] = b; path[2] = c;
  endtask

  always @(negedge clk) if (rst_n && m_valid) begin
    chk("resp_addr", int'(m_addr), e_addr);
    chk("resp_found", int'(m_found), e_found);
    chk("resp_created", int'(m_created), e_created);
    chk("resp_err", int'(m_err), e_err);
    chk("resp_used_cnt", int'(used_cnt), mused);
    chk("resp_s_ready", int'(s_ready), 0);
  end

  task automatic run_path(input bit ins, input int hold);
    int w;
    model_run(ins);
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      s_valid = 1; s_id = 8'(path[i]); s_last = (i == plen - 1); s_insert = ins;
      #1; w = 0;
      while (!s_ready && w < 50) begin @(negedge clk); #1; w++; end
      if (!s_ready) begin chk("accept_timeout", 0, 1); s_valid = 0; return; end
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 0; s_last = 0;
    lat = 0;
    while (!m_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!m_valid) begin chk("resp_timeout", 0, 1); return; end
    c_addr = m_addr; c_found = m_found; c_created = m_created; c_err = m_err;
    repeat (hold) @(negedge clk);
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    chk("resp_release", int'(m_valid), 0);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    model_clear();
    chk("clr_used_cnt", int'(used_cnt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_used_cnt", int'(used_cnt), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_addr", int'(m_addr), 0);
    chk("rst_m_flags", int'({m_found, m_created, m_err}), 0);
    rst_n = 1;
    // Insert [3,5] on an empty table
    set_path(2, 3, 5); run_path(1, 0);
    chk("t1_addr", c_addr, 2);
    chk("t1_created", c_created, 1);
    chk("t1_found", c_found, 0);
    chk("t1_used", int'(used_cnt), 3);
    chk("t1_parent2", int'(dut.u_table.r_par[2]), 1);
    chk("t1_parent1", int'(dut.u_table.r_par[1]), 0);
    // Lookups
    set_path(2, 3, 5); run_path(0, 0);
    chk("t2_addr", c_addr, 2);
    chk("t2_found", c_found, 1);
    chk("t2_err", c_err, 0);
    set_path(2, 3, 7); run_path(0, 0);
    chk("t2_miss_err", c_err, 3);
    chk("t2_miss_addr", c_addr, 0);
    // Child slot exhaustion on a fresh table
    do_clr();
    for (int i = 9; i <= 12; i++) begin set_path(1, i); run_path(1, 0); end
    set_path(1, 13); run_path(1, 0);
    chk("t3_full_err", c_err, 2);
    chk("t3_full_used", int'(used_cnt), 5);
    set_path(1, 12); run_path(0, 0);
    chk("t3_scan_lat", lat, 4);
    chk("t3_lookup12", c_addr, 4);
    set_path(1, 13); run_path(0, 0);
    chk("t3_no13", c_err, 3);
    // Bad id with backpressure
    set_path(3, 0, 4, 4); run_path(1, 5);
    chk("t4_err", c_err, 1);
    chk("t4_created", c_created, 0);
    chk("t4_used", int'(used_cnt), 5);
    // Fill the table with one deep chain
    do_clr();
    plen = NN - 1;
    for (int i = 0; i < plen; i++) path[i] = 1;
    run_path(1, 0);
    chk("t5_chain_addr", c_addr, NN - 1);
    chk("t5_used", int'(used_cnt), NN);
    set_path(1, 2); run_path(1, 0);
    chk("t5_full_err", c_err, 3);
    chk("t5_full_used", int'(used_cnt), NN);
    @(negedge clk);
    clr = 1; s_valid = 1; s_id = 8'd1; s_last = 1;
    #1 chk("t5_clr_wins", int'(s_ready), 0);
    @(negedge clk);
    clr = 0; s_valid = 0; s_last = 0;
    model_clear();
    chk("t5_clr_used", int'(used_cnt), 1);
    set_path(1, 1); run_path(0, 0);
    chk("t5_old_path", c_err, 3);
    // Async reset during ALLOC
    @(negedge clk);
    s_valid = 1; s_id = 8'd3; s_last = 0; s_insert = 1;
    @(posedge clk);
    @(negedge clk); s_valid = 0;
    @(posedge clk);
    #1 chk("t6_in_alloc", int'(dut.r_state), int'(ALLOC));
    rst_n = 0;
    #1;
    chk("t6_used", int'(used_cnt), 1);
    chk("t6_s_ready", int'(s_ready), 1);
    chk("t6_m_valid", int'(m_valid), 0);
    @(negedge clk); rst_n = 1;
    model_clear();
    set_path(2, 3, 5); run_path(1, 0);
    chk("t6_addr", c_addr, 2);
    chk("t6_used_after", int'(used_cnt), 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
